// File: rtl/soft_backward_sched.sv
// Step sequencer for the soft_backward beta recursion: seeds the lattice, walks t from N-1
// down to 0, feeds each engine result back as the next input and publishes every step.
module soft_backward_sched #(
    parameter int                 DATA_WIDTH = 6,
    parameter int                 n          = 5,
    parameter int                 a          = 9,
    parameter logic signed [31:0] ONE        = 32'sd16777216,
    parameter int                 INIT_ROW   = 9,
    parameter int                 INIT_COL   = 0,
    parameter int                 TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic signed [31:0]           N_in,
    input  logic        [DATA_WIDTH-1:0] strand_in,
    output logic                         busy,
    output logic                         run_done,
    output logic                         err,
    output logic                         calc_beta,
    output logic signed [31:0]           t,
    output logic signed [31:0]           N,
    output logic        [DATA_WIDTH-1:0] strand,
    output logic signed [31:0]           beta_in   [2*n:0][DATA_WIDTH:-n],
    input  logic signed [31:0]           beta_out  [2*n:0][DATA_WIDTH:-n],
    input  logic                         done,
    output logic                         step_valid,
    output logic signed [31:0]           step_t,
    output logic signed [31:0]           beta_step [2*n:0][DATA_WIDTH:-n]
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    // The engine width parameter a is only carried for the instance pairing.
    if (a < 0 || INIT_ROW < 0 || INIT_ROW > 2*n || INIT_COL < -n || INIT_COL > DATA_WIDTH)
    begin : g_bad_cfg
        $error("soft_backward_sched: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_e;

    state_e                 state_q;
    logic                   busy_q, run_done_q, err_q, calc_beta_q, step_valid_q;
    logic                   seen_low_q;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   accept_d;
    logic signed [31:0]     t_q, N_q, step_t_q;
    logic [DATA_WIDTH-1:0]  strand_q;
    logic signed [31:0]     beta_in_q   [2*n:0][DATA_WIDTH:-n];
    logic signed [31:0]     beta_step_q [2*n:0][DATA_WIDTH:-n];

    always_comb begin
        wd_d     = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
        // A done that was never seen low in this wait is left over from the previous step.
        accept_d = done && seen_low_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
            calc_beta_q  <= 1'b0;
            step_valid_q <= 1'b0;
            seen_low_q   <= 1'b0;
            wd_q         <= '0;
            t_q          <= '0;
            N_q          <= '0;
            step_t_q     <= '0;
            strand_q     <= '0;
            for (int r = 0; r <= 2*n; r++)
                for (int c = -n; c <= DATA_WIDTH; c++) begin
                    beta_in_q[r][c]   <= '0;
                    beta_step_q[r][c] <= '0;
                end
        end else begin
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
            calc_beta_q  <= 1'b0;
            step_valid_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (N_in >= 1) begin
                                N_q         <= N_in;
                                strand_q    <= strand_in;
                                t_q         <= N_in - 1;
                                calc_beta_q <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= S_ISSUE;
                                for (int r = 0; r <= 2*n; r++)
                                    for (int c = -n; c <= DATA_WIDTH; c++)
                                        beta_in_q[r][c] <= (r == INIT_ROW && c == INIT_COL) ? ONE : '0;
                            end else begin
                                run_done_q <= 1'b1;
                                err_q      <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        wd_q       <= '0;
                        seen_low_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                    S_WAIT: begin
                        seen_low_q <= seen_low_q | ~done;
                        if (accept_d) begin
                            beta_in_q    <= beta_out;
                            beta_step_q  <= beta_out;
                            step_t_q     <= t_q;
                            step_valid_q <= 1'b1;
                            if (t_q == 0) begin
                                state_q <= S_FINISH;
                            end else begin
                                t_q         <= t_q - 1;
                                calc_beta_q <= 1'b1;
                                state_q     <= S_ISSUE;
                            end
                        end else if (wd_d == WD_W'(TIMEOUT)) begin
                            run_done_q <= 1'b1;
                            err_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            wd_q <= wd_d;
                        end
                    end
                    S_FINISH: begin
                        run_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign run_done   = run_done_q;
    assign err        = err_q;
    assign calc_beta  = calc_beta_q;
    assign t          = t_q;
    assign N          = N_q;
    assign strand     = strand_q;
    assign beta_in    = beta_in_q;
    assign step_valid = step_valid_q;
    assign step_t     = step_t_q;
    assign beta_step  = beta_step_q;

endmodule

// File: tb/tb_soft_backward_sched.sv
// Bench for soft_backward_sched: a cycle-level engine model drives done/beta_out, and the
// expected step sequence and lattices are computed from the recursion rules directly.
module tb_soft_backward_sched;

    localparam int                 DW    = 6;
    localparam int                 NN    = 5;
    localparam int                 TOUT  = 16;
    localparam int                 IR    = 9;
    localparam int                 IC    = 0;
    localparam logic signed [31:0] ONE   = 32'sd16777216;
    localparam logic signed [31:0] JUNK  = 32'sd777;
    localparam int                 M_NORMAL = 0;
    localparam int                 M_STALE  = 1;
    localparam int                 M_TO     = 2;

    logic                  clk = 1'b0;
    logic                  rst, start, abort, done;
    logic signed [31:0]    N_in, t, N, step_t;
    logic [DW-1:0]         strand_in, strand;
    logic                  busy, run_done, err, calc_beta, step_valid;
    logic signed [31:0]    beta_in   [2*NN:0][DW:-NN];
    logic signed [31:0]    beta_out  [2*NN:0][DW:-NN];
    logic signed [31:0]    beta_step [2*NN:0][DW:-NN];

    int checks = 0;
    int errors = 0;

    // Observations collected by drive_run for the scenario tasks to judge.
    int                 st_q[$];
    logic signed [31:0] b90_q[$];
    logic signed [31:0] corner_q[$];
    int                 rd_pulses, rd_err, rd_cyc, rd_busy, first_calc, calc_cnt, b2b;
    logic signed [31:0] n_last;
    logic [DW-1:0]      strand_last;

    soft_backward_sched #(
        .DATA_WIDTH(DW), .n(NN), .a(9), .ONE(ONE),
        .INIT_ROW(IR), .INIT_COL(IC), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .N_in(N_in), .strand_in(strand_in),
        .busy(busy), .run_done(run_done), .err(err), .calc_beta(calc_beta),
        .t(t), .N(N), .strand(strand),
        .beta_in(beta_in), .beta_out(beta_out), .done(done),
        .step_valid(step_valid), .step_t(step_t), .beta_step(beta_step)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end, required it to end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_out_plus1();
        for (int r = 0; r <= 2*NN; r++)
            for (int c = -NN; c <= DW; c++)
                beta_out[r][c] = beta_in[r][c] + 32'sd1;
    endtask

    task automatic set_out_const(input logic signed [31:0] v);
        for (int r = 0; r <= 2*NN; r++)
            for (int c = -NN; c <= DW; c++)
                beta_out[r][c] = v;
    endtask

    // Engine model: done comes 3 cycles after calc_beta is seen. In stale mode done is
    // otherwise held high with junk data, dropping for a single cycle before the real result.
    task automatic drive_run(input int nval, input logic [DW-1:0] sv, input int mode, input bit poke);
        int off = 100;
        int end_at = -1;
        bit prev_sv = 0, prev_rd = 0;
        st_q.delete(); b90_q.delete(); corner_q.delete();
        rd_pulses = 0; rd_err = -1; rd_cyc = -1; rd_busy = -1; first_calc = -1;
        calc_cnt = 0; b2b = 0; n_last = 0; strand_last = '0;
        if (mode == M_STALE) begin done = 1'b1; set_out_const(JUNK); end
        else done = 1'b0;
        N_in = nval; strand_in = sv; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (step_valid) begin
                st_q.push_back(step_t);
                b90_q.push_back(beta_step[IR][IC]);
                corner_q.push_back(beta_step[0][-NN]);
            end
            if ((step_valid && prev_sv) || (run_done && prev_rd)) b2b++;
            prev_sv = step_valid; prev_rd = run_done;
            if (busy) begin n_last = N; strand_last = strand; end
            if (calc_beta) begin
                calc_cnt++;
                if (first_calc < 0) first_calc = cyc;
                off = 0;
            end else if (off < 1000) off++;
            if (run_done) begin
                rd_pulses++; rd_err = err; rd_busy = busy;
                if (rd_cyc < 0) rd_cyc = cyc;
                if (end_at < 0) end_at = cyc + 4;
            end
            if (poke && cyc == 5) begin
                start = 1'b1; N_in = 7; strand_in = ~sv;
            end else start = 1'b0;
            if (mode == M_TO) done = 1'b0;
            else if (off == 3) begin done = 1'b1; set_out_plus1(); end
            else if (mode == M_STALE && off != 2) begin done = 1'b1; set_out_const(JUNK); end
            else done = 1'b0;
            if (cyc == end_at) break;
            tick();
        end
        done = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic advance_to_t2(output int svc, output bit ok);
        int off = 100;
        svc = 0; ok = 0;
        N_in = 5; strand_in = 6'b110011; start = 1'b1; done = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (step_valid) svc++;
            if (calc_beta) off = 0; else if (off < 1000) off++;
            if (off == 3) begin
                done = 1'b1; set_out_plus1();
                if (t == 2) begin ok = 1; return; end
            end else done = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        int nz = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; done = 1'b0; N_in = 0; strand_in = '0;
        set_out_const(32'sd0);
        tick(); tick();
        for (int r = 0; r <= 2*NN; r++)
            for (int c = -NN; c <= DW; c++)
                if (beta_in[r][c] !== 0 || beta_step[r][c] !== 0) nz++;
        checks++; if ({busy, run_done, err, calc_beta, step_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 00000", {busy, run_done, err, calc_beta, step_valid}); end
        checks++; if (t !== 0 || N !== 0 || step_t !== 0 || strand !== 0) begin
            errors++; $display("FAIL reset_regs: got t=%0d N=%0d step_t=%0d strand=%0d required all 0", t, N, step_t, strand); end
        checks++; if (nz !== 0) begin
            errors++; $display("FAIL reset_lattice: got %0d nonzero elements required 0", nz); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_seed();
        int bad = 0;
        N_in = 5; strand_in = 6'b010101; start = 1'b1; done = 1'b0;
        tick();
        start = 1'b0;
        for (int r = 0; r <= 2*NN; r++)
            for (int c = -NN; c <= DW; c++)
                if (beta_in[r][c] !== ((r == IR && c == IC) ? ONE : 32'sd0)) bad++;
        checks++; if (calc_beta !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL seed_issue: got calc_beta=%b busy=%b required 1 1", calc_beta, busy); end
        checks++; if (t !== 4 || N !== 5 || strand !== 6'b010101) begin
            errors++; $display("FAIL seed_regs: got t=%0d N=%0d strand=%b required 4 5 010101", t, N, strand); end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL seed_lattice: got %0d wrong elements required 0", bad); end
        tick();
        checks++; if (calc_beta !== 1'b0) begin
            errors++; $display("FAIL seed_pulse: got calc_beta=%b in WAIT required 0", calc_beta); end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if (busy !== 1'b0 || run_done !== 1'b0) begin
            errors++; $display("FAIL seed_abort: got busy=%b run_done=%b required 0 0", busy, run_done); end
        tick();
    endtask

    task automatic check_steps(input string nm, input int nval);
        checks++; if (st_q.size() !== nval) begin
            errors++; $display("FAIL %s_count: got %0d step pulses required %0d", nm, st_q.size(), nval); end
        for (int k = 0; k < st_q.size() && k < nval; k++) begin
            checks++; if (st_q[k] !== nval - 1 - k || b90_q[k] !== ONE + k + 1 || corner_q[k] !== k + 1) begin
                errors++; $display("FAIL %s_step%0d: got t=%0d seed=%0d other=%0d required %0d %0d %0d",
                    nm, k, st_q[k], b90_q[k], corner_q[k], nval - 1 - k, ONE + k + 1, k + 1); end
        end
        checks++; if (rd_pulses !== 1 || rd_err !== 0 || rd_busy !== 0 || b2b !== 0) begin
            errors++; $display("FAIL %s_done: got pulses=%0d err=%0d busy=%0d b2b=%0d required 1 0 0 0",
                nm, rd_pulses, rd_err, rd_busy, b2b); end
    endtask

    task automatic test_full_run();
        int nval, bad;
        logic [DW-1:0] sv;
        for (int it = 0; it < 3; it++) begin
            nval = (it == 0) ? 5 : int'($urandom_range(1, 6));
            sv = DW'($urandom);
            drive_run(nval, sv, M_NORMAL, 1'b0);
            check_steps("full", nval);
            checks++; if (calc_cnt !== nval || strand_last !== sv) begin
                errors++; $display("FAIL full_issue: got calc=%0d strand=%0d required %0d %0d", calc_cnt, strand_last, nval, sv); end
            if (it == 0) begin
                bad = 0;
                for (int r = 0; r <= 2*NN; r++)
                    for (int c = -NN; c <= DW; c++)
                        if (beta_step[r][c] !== ((r == IR && c == IC) ? ONE + 5 : 32'sd5)) bad++;
                checks++; if (bad !== 0 || beta_step[IR][IC] !== 32'sd16777221) begin
                    errors++; $display("FAIL full_final_lattice: got %0d wrong elements, seed=%0d required 0 16777221", bad, beta_step[IR][IC]); end
            end
        end
    endtask

    task automatic test_stale_done();
        drive_run(5, 6'b100110, M_STALE, 1'b0);
        check_steps("stale", 5);
    endtask

    task automatic test_timeout();
        drive_run(3, 6'b001111, M_TO, 1'b0);
        checks++; if (rd_pulses !== 1 || rd_err !== 1 || st_q.size() !== 0) begin
            errors++; $display("FAIL timeout_done: got pulses=%0d err=%0d steps=%0d required 1 1 0", rd_pulses, rd_err, st_q.size()); end
        checks++; if (rd_cyc - first_calc !== TOUT + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles after issue required %0d", rd_cyc - first_calc, TOUT + 1); end
        checks++; if (beta_in[IR][IC] !== ONE || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_hold: got seed=%0d busy=%b required %0d 0", beta_in[IR][IC], busy, ONE); end
    endtask

    task automatic test_bad_n();
        int vals[2] = '{0, -3};
        foreach (vals[i]) begin
            drive_run(vals[i], 6'b111000, M_NORMAL, 1'b0);
            checks++; if (rd_pulses !== 1 || rd_err !== 1 || rd_cyc !== 0 || calc_cnt !== 0 || st_q.size() !== 0) begin
                errors++; $display("FAIL bad_n_%0d: got pulses=%0d err=%0d at=%0d calc=%0d steps=%0d required 1 1 0 0 0",
                    vals[i], rd_pulses, rd_err, rd_cyc, calc_cnt, st_q.size()); end
        end
    endtask

    task automatic test_ignored_start();
        drive_run(5, 6'b010110, M_NORMAL, 1'b1);
        check_steps("busy_start", 5);
        checks++; if (n_last !== 5 || strand_last !== 6'b010110) begin
            errors++; $display("FAIL busy_start_latch: got N=%0d strand=%b required 5 010110", n_last, strand_last); end
    endtask

    task automatic test_abort_mid_run();
        int svc, extra = 0;
        bit ok;
        advance_to_t2(svc, ok);
        checks++; if (ok !== 1'b1 || svc !== 2) begin
            errors++; $display("FAIL abort_reach: got reached=%0d steps=%0d required 1 2", ok, svc); end
        abort = 1'b1;
        tick();
        abort = 1'b0; done = 1'b0;
        checks++; if ({busy, step_valid, run_done, calc_beta} !== 4'b0) begin
            errors++; $display("FAIL abort_next: got %b required 0000", {busy, step_valid, run_done, calc_beta}); end
        checks++; if (beta_step[IR][IC] !== ONE + 2) begin
            errors++; $display("FAIL abort_nocapture: got %0d required %0d", beta_step[IR][IC], ONE + 2); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (run_done || step_valid || busy) extra++;
        end
        checks++; if (extra !== 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int svc, nz = 0;
        bit ok;
        advance_to_t2(svc, ok);
        rst = 1'b1;
        tick();
        done = 1'b0;
        for (int r = 0; r <= 2*NN; r++)
            for (int c = -NN; c <= DW; c++)
                if (beta_in[r][c] !== 0 || beta_step[r][c] !== 0) nz++;
        checks++; if ({busy, run_done, err, calc_beta, step_valid} !== 5'b0 || t !== 0 || N !== 0 || step_t !== 0 || strand !== 0) begin
            errors++; $display("FAIL rst_mid_regs: got flags=%b t=%0d N=%0d step_t=%0d strand=%0d required all 0",
                {busy, run_done, err, calc_beta, step_valid}, t, N, step_t, strand); end
        checks++; if (nz !== 0 || ok !== 1'b1) begin
            errors++; $display("FAIL rst_mid_lattice: got %0d nonzero, reached=%0d required 0 1", nz, ok); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_seed();
        test_full_run();
        test_stale_done();
        test_timeout();
        test_bad_n();
        test_ignored_start();
        test_abort_mid_run();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
